// File: rtl/control_calculadora.sv
// control_calculadora: keypad-to-ALU sequencer for the 4-digit BCD calculator; define BORRAR_DIGITO_EN to enable the D backspace key
module control_calculadora #(
  parameter int MAX_DIGITOS = 4,
  parameter int TIMEOUT_ALU = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tecla_en,
  input  logic [3:0]  tecla,
  input  logic        alu_listo,
  input  logic        alu_error,
  input  logic [15:0] alu_resultado,
  output logic        alu_start,
  output logic        alu_op,
  output logic [15:0] operando_a,
  output logic [15:0] operando_b,
  output logic [15:0] display,
  output logic [2:0]  contador,
  output logic [2:0]  estado,
  output logic        error
);
  typedef enum logic [2:0] {
    INGRESO_A  = 3'd0,
    INGRESO_B  = 3'd1,
    CALCULO    = 3'd2,
    ESPERA_ALU = 3'd3,
    RESULTADO  = 3'd4,
    ERROR      = 3'd5
  } estado_t;
  estado_t est, est_n;
  logic prev_en, op, op_n, ev, es_dig, es_op;
  logic [15:0] a, a_n, b, b_n, r, r_n, cur, cur_n, to, to_n;
  logic [2:0] cnt, cnt_n, cnt_d;
  assign ev = tecla_en & ~prev_en;
  assign es_dig = ev & (tecla <= 4'd9);
  assign es_op = ev & (tecla == 4'hA || tecla == 4'hB);
  assign alu_start = est == CALCULO;
  assign alu_op = op;
  assign operando_a = a;
  assign operando_b = b;
  assign contador = cnt;
  assign estado = est;
  assign error = est == ERROR;
  assign display = est == INGRESO_A ? a :
                   est == RESULTADO ? r :
                   est == ERROR     ? 16'hEEEE : b;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      est <= INGRESO_A;
      prev_en <= 1'b0;
      op <= 1'b0;
      a <= '0;
      b <= '0;
      r <= '0;
      to <= '0;
      cnt <= '0;
    end else begin
      est <= est_n;
      prev_en <= tecla_en;
      op <= op_n;
      a <= a_n;
      b <= b_n;
      r <= r_n;
      to <= to_n;
      cnt <= cnt_n;
    end
  end
  // cur/cur_n is the operand being edited; only committed in the entry states
  always_comb begin
    est_n = est;
    a_n = a;
    b_n = b;
    r_n = r;
    op_n = op;
    cnt_n = cnt;
    to_n = '0;
    cur = est == INGRESO_B ? b : a;
    cur_n = cur;
    cnt_d = cnt;
    if (es_dig && !(cnt == 3'd0 && tecla == 4'd0) && cnt < 3'(MAX_DIGITOS)) begin
      cur_n = {cur[11:0], tecla};
      cnt_d = cnt + 3'd1;
    end
`ifdef BORRAR_DIGITO_EN
    else if (ev && tecla == 4'hD && cnt != 3'd0) begin
      cur_n = {4'h0, cur[15:4]};
      cnt_d = cnt - 3'd1;
    end
`endif
    case (est)
      INGRESO_A: begin
        a_n = cur_n;
        cnt_n = cnt_d;
        if (es_op) begin
          op_n = tecla[0];
          b_n = '0;
          cnt_n = '0;
          est_n = INGRESO_B;
        end
      end
      INGRESO_B: begin
        b_n = cur_n;
        cnt_n = cnt_d;
        op_n = es_op && cnt == 3'd0 ? tecla[0] : op;
        est_n = ev && tecla == 4'hE ? CALCULO : INGRESO_B;
      end
      CALCULO: est_n = ESPERA_ALU;
      ESPERA_ALU: begin
        if (alu_listo) begin
          est_n = alu_error ? ERROR : RESULTADO;
          r_n = alu_error ? r : alu_resultado;
        end else if (to == 16'(TIMEOUT_ALU - 1)) est_n = ERROR;
        else to_n = to + 16'd1;
      end
      RESULTADO: begin
        if (es_dig) begin
          a_n = {12'h0, tecla};
          cnt_n = {2'b0, tecla != 4'd0};
          b_n = '0;
          est_n = INGRESO_A;
        end else if (es_op) begin
          a_n = r;
          b_n = '0;
          cnt_n = '0;
          op_n = tecla[0];
          est_n = INGRESO_B;
        end
      end
      ERROR: est_n = ERROR;
      default: est_n = INGRESO_A;
    endcase
    if (ev && tecla == 4'hC) begin
      est_n = INGRESO_A;
      a_n = '0;
      b_n = '0;
      r_n = '0;
      cnt_n = '0;
      op_n = 1'b0;
      to_n = '0;
    end
  end
endmodule

// File: tb/tb_control_calculadora.sv
// tb_control_calculadora: directed bench for the calculator sequencer (ALU timeout shortened to 8)
module tb_control_calculadora;
  logic clk = 0, reset = 0, tecla_en = 0, alu_listo = 0, alu_error = 0;
  logic [3:0] tecla = 0;
  logic [15:0] alu_resultado = 0;
  logic alu_start, alu_op, error;
  logic [15:0] operando_a, operando_b, display;
  logic [2:0] contador, estado;
  int checks = 0, failures = 0, starts = 0, viol = 0;
  logic prev_start = 0;

  control_calculadora #(.MAX_DIGITOS(4), .TIMEOUT_ALU(8)) dut (
    .clk(clk), .reset(reset), .tecla_en(tecla_en), .tecla(tecla),
    .alu_listo(alu_listo), .alu_error(alu_error), .alu_resultado(alu_resultado),
    .alu_start(alu_start), .alu_op(alu_op), .operando_a(operando_a),
    .operando_b(operando_b), .display(display), .contador(contador),
    .estado(estado), .error(error)
  );

  always #5 clk = ~clk;

  // start pulses must be single-cycle and only while estado is CALCULO
  always @(negedge clk) begin
    if (alu_start) begin
      starts <= starts + 1;
      if (prev_start || estado != 3'd2) viol <= viol + 1;
    end
    prev_start <= alu_start;
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk); tecla = k; tecla_en = 1;
    @(negedge clk); tecla_en = 0;
  endtask

  task automatic alu_reply(input logic [15:0] res, input logic err);
    @(negedge clk); alu_listo = 1; alu_error = err; alu_resultado = res;
    @(negedge clk); alu_listo = 0; alu_error = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    checks++; if ({alu_start, alu_op, operando_a, operando_b, display, contador, estado, error} !== 56'h0) begin
      failures++; $display("FAIL reset_outputs got a=%h b=%h d=%h c=%0d e=%0d st=%b op=%b err=%b", operando_a, operando_b, display, contador, estado, alu_start, alu_op, error);
    end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_add;
    int s0;
    s0 = starts;
    press(1); press(2); press(3); press(4'hA); press(4); press(5); press(4'hE);
    checks++; if (estado !== 3'd2 || alu_start !== 1'b1) begin failures++; $display("FAIL add_calculo got estado=%0d start=%b exp 2 1", estado, alu_start); end
    checks++; if (operando_a !== 16'h0123 || operando_b !== 16'h0045 || alu_op !== 1'b0) begin
      failures++; $display("FAIL add_operands got a=%h b=%h op=%b exp 0123 0045 0", operando_a, operando_b, alu_op);
    end
    @(negedge clk);
    alu_reply(16'h0168, 0);
    checks++; if (display !== 16'h0168 || estado !== 3'd4) begin failures++; $display("FAIL add_result got display=%h estado=%0d exp 0168 4", display, estado); end
    checks++; if (starts - s0 !== 1) begin failures++; $display("FAIL add_one_start got %0d exp 1", starts - s0); end
  endtask

  task automatic test_entry;
    press(4'hC);
    press(1); press(2); press(3); press(4); press(5);
    checks++; if (operando_a !== 16'h1234 || contador !== 3'd4) begin failures++; $display("FAIL entry_max got a=%h c=%0d exp 1234 4", operando_a, contador); end
    press(4'hC);
    press(0); press(0); press(7);
    checks++; if (operando_a !== 16'h0007 || contador !== 3'd1 || estado !== 3'd0) begin
      failures++; $display("FAIL entry_zeros got a=%h c=%0d e=%0d exp 0007 1 0", operando_a, contador, estado);
    end
  endtask

  task automatic test_hold;
    press(4'hC);
    @(negedge clk); tecla = 3; tecla_en = 1;
    repeat (10) @(negedge clk);
    tecla_en = 0;
    @(negedge clk);
    checks++; if (operando_a !== 16'h0003 || contador !== 3'd1) begin failures++; $display("FAIL hold_once got a=%h c=%0d exp 0003 1", operando_a, contador); end
    press(4'hF);
    checks++; if (operando_a !== 16'h0003 || contador !== 3'd1 || estado !== 3'd0) begin
      failures++; $display("FAIL key_f got a=%h c=%0d e=%0d exp 0003 1 0", operando_a, contador, estado);
    end
  endtask

  task automatic test_alu_error;
    press(4'hA); press(4'hE);
    @(negedge clk);
    alu_reply(16'h1234, 1);
    checks++; if (error !== 1'b1 || display !== 16'hEEEE || estado !== 3'd5) begin
      failures++; $display("FAIL alu_error got err=%b d=%h e=%0d exp 1 EEEE 5", error, display, estado);
    end
    press(5); press(4'hE);
    checks++; if (error !== 1'b1 || display !== 16'hEEEE || estado !== 3'd5) begin
      failures++; $display("FAIL error_sticky got err=%b d=%h e=%0d exp 1 EEEE 5", error, display, estado);
    end
    press(4'hC);
    checks++; if (estado !== 3'd0 || operando_a !== 16'h0 || operando_b !== 16'h0 || error !== 1'b0) begin
      failures++; $display("FAIL error_clear got e=%0d a=%h b=%h err=%b exp 0 0 0 0", estado, operando_a, operando_b, error);
    end
  endtask

  task automatic test_timeout;
    press(1); press(4'hA); press(2); press(4'hE);
    @(negedge clk);
    checks++; if (estado !== 3'd3) begin failures++; $display("FAIL to_enter got %0d exp 3", estado); end
    repeat (7) @(negedge clk);
    checks++; if (estado !== 3'd3) begin failures++; $display("FAIL to_early got %0d exp 3", estado); end
    @(negedge clk);
    checks++; if (estado !== 3'd5 || error !== 1'b1) begin failures++; $display("FAIL to_error got e=%0d err=%b exp 5 1", estado, error); end
    press(4'hC);
    press(1); press(4'hA); press(2); press(4'hE);
    @(negedge clk);
    press(4'hC);
    alu_reply(16'h0999, 0);
    checks++; if (estado !== 3'd0 || display !== 16'h0 || operando_a !== 16'h0) begin
      failures++; $display("FAIL abort got e=%0d d=%h a=%h exp 0 0 0", estado, display, operando_a);
    end
  endtask

  task automatic test_chain;
    press(1); press(2); press(3); press(4'hA); press(4); press(5); press(4'hE);
    @(negedge clk);
    alu_reply(16'h0168, 0);
    press(4'hB); press(8); press(4'hE);
    checks++; if (operando_a !== 16'h0168 || alu_op !== 1'b1 || operando_b !== 16'h0008 || estado !== 3'd2) begin
      failures++; $display("FAIL chain got a=%h op=%b b=%h e=%0d exp 0168 1 0008 2", operando_a, alu_op, operando_b, estado);
    end
    @(negedge clk);
    alu_reply(16'h0160, 0);
    checks++; if (display !== 16'h0160) begin failures++; $display("FAIL chain_result got %h exp 0160", display); end
    press(7);
    checks++; if (estado !== 3'd0 || operando_a !== 16'h0007 || contador !== 3'd1 || operando_b !== 16'h0) begin
      failures++; $display("FAIL result_digit got e=%0d a=%h c=%0d b=%h exp 0 0007 1 0", estado, operando_a, contador, operando_b);
    end
  endtask

  task automatic test_backspace;
    press(4'hC);
    press(1); press(2); press(4'hD);
`ifdef BORRAR_DIGITO_EN
    checks++; if (operando_a !== 16'h0001 || contador !== 3'd1) begin failures++; $display("FAIL backspace got a=%h c=%0d exp 0001 1", operando_a, contador); end
`else
    checks++; if (operando_a !== 16'h0012 || contador !== 3'd2) begin failures++; $display("FAIL d_ignored got a=%h c=%0d exp 0012 2", operando_a, contador); end
`endif
  endtask

  task automatic test_start_pulses;
    checks++; if (viol !== 0) begin failures++; $display("FAIL start_pulse got %0d bad pulses exp 0", viol); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_entry;
    test_hold;
    test_alu_error;
    test_timeout;
    test_chain;
    test_backspace;
    test_start_pulses;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/control_calculadora.md
Name: control_calculadora

Overview:
Top-level sequencer for the 4-digit BCD keypad calculator. It turns keypad strobes into operand entry for A and B, latches the operator, and hands the operands to the ALU with a start/done handshake. It then latches the result or error and selects what the display shows. It sits between the keypad decoder and the ALU/display datapath, replacing ad-hoc per-operand entry logic.

Parameters:
MAX_DIGITOS, 4, digits accepted per operand (1..4); extra digits are ignored.
TIMEOUT_ALU, 1000, cycles spent in ESPERA_ALU without alu_listo before entering ERROR (1..65535).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
tecla_en  input  1  key-held level from keypad, already synchronous to clk
tecla  input  4  key code: 0-9 digit, A add, B sub, C clear, E equals, D backspace (feature only); others ignored
alu_listo  input  1  ALU done, 1-cycle pulse
alu_error  input  1  ALU overflow/negative, qualified by alu_listo
alu_resultado  input  16  BCD result, qualified by alu_listo
alu_start  output  1  1-cycle ALU start pulse
alu_op  output  1  0 add, 1 sub
operando_a  output  16  BCD operand A
operando_b  output  16  BCD operand B
display  output  16  BCD/hex word to display
contador  output  3  digits entered in the current operand (0..MAX_DIGITOS)
estado  output  3  state code (debug)
error  output  1  high in ERROR

Behaviour:
- Reset: state INGRESO_A, all registers 0. Every output is 0, including display and alu_start.
- Key event: tecla_en=1 and registered previous tecla_en=0. Exactly one event per press, regardless of hold length. The previous-level register resets to 0. The event and tecla are acted on at that clock edge.
- Digit rule on the current operand: if contador==0 and digit==0, no change. Else if contador<MAX_DIGITOS, operand <= {operand[11:0], digit} and contador+1. Else ignored.
- States, Moore-encoded on estado:
- INGRESO_A (0): display=A. Digit: digit rule on A. A/B key: alu_op <= (key==B), B<=0, contador<=0, go to INGRESO_B. E: ignored.
- INGRESO_B (1): display=B. Digit: digit rule on B. A/B key: if contador==0, replace alu_op; else ignored. E: go to CALCULO.
- CALCULO (2): alu_start=1 for this single cycle, then unconditionally go to ESPERA_ALU. Keys other than C are ignored. alu_listo is ignored here.
- ESPERA_ALU (3): the timeout counter counts from 0.
- alu_listo & alu_error: go to ERROR.
- alu_listo & !alu_error: R <= alu_resultado, go to RESULTADO.
- Counter reaches TIMEOUT_ALU-1 with no alu_listo: go to ERROR.
- alu_listo wins over timeout in the same cycle.
- RESULTADO (4): display=R. Digit: A<=digit, contador<=(digit!=0), B<=0, go to INGRESO_A. A/B key (chaining): A<=R, B<=0, contador<=0, alu_op set, go to INGRESO_B. E: ignored.
- ERROR (5): display=16'hEEEE, error=1. Only C leaves.
- C key, any state: A, B, R, contador, alu_op and the timeout counter cleared; go to INGRESO_A. In CALCULO/ESPERA_ALU this aborts the operation, and a later alu_listo is ignored because the state is no longer ESPERA_ALU.
- Latency: E edge, then alu_start on the next cycle, then earliest result 1 cycle after alu_start. Result visible on display the cycle after alu_listo.
- alu_start never asserts outside CALCULO and never for 2 consecutive cycles.
- Unused state codes 6/7 go to INGRESO_A.

Optional Feature:
BORRAR_DIGITO_EN. When defined, key D in INGRESO_A/INGRESO_B does operand <= {4'h0, operand[15:4]}, contador-1 (no change when contador==0); D is ignored in other states. When undefined, D is ignored everywhere and no backspace logic exists.

Test Plan:
- Reset; keys 1,2,3,A,4,5,E; ALU returns listo with 16'h0168 3 cycles after start. Expect exactly one alu_start pulse, operando_a=16'h0123, operando_b=16'h0045, alu_op=0, then display=16'h0168, estado=4.
- Keys 1,2,3,4,5 give A=16'h1234, contador=4. After C, keys 0,0,7 give A=16'h0007, contador=1.
- tecla_en held high 10 cycles with tecla=3 gives A=16'h0003 only. Key F gives no change.
- Start a calculation; alu_listo=1 with alu_error=1 gives error=1, display=16'hEEEE. Digits 5 and E are ignored. C gives estado=0, A=B=0, error=0.
- TIMEOUT_ALU=8 with no alu_listo enters ERROR 8 cycles after entering ESPERA_ALU. C pressed in ESPERA_ALU then a late alu_listo leaves estado=0, display=0.
- From RESULTADO 16'h0168: keys B,8,E give operando_a=16'h0168, alu_op=1, operando_b=16'h0008. With BORRAR_DIGITO_EN, keys 1,2,D in INGRESO_A give A=16'h0001, contador=1.
